// File: rtl/memboard_pkg.sv
// Shared widths, defaults and helpers for the memory-board instruction path.
package memboard_pkg;

    localparam int INSTR_W            = 32;
    localparam int PIPE_W             = 16;
    localparam int DEPTH_LOG2_DEFAULT = 9;
    localparam int BLOCK_LEN_DEFAULT  = 64;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [PIPE_W-1:0]  half_t;

    // Host sends the low half first, so the second half lands on top.
    function automatic instr_t pack_halves(input half_t hi, input half_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no array reset.
// A read of the address being written in the same cycle returns the old contents.
module sdp_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_input_buffer.sv
// Instruction input buffer: packs host 16-bit half-words into 32-bit instructions,
// queues them in a RAM-backed FIFO and presents the head first-word-fall-through.
//
// The RAM read port always addresses the post-edge head slot, so its registered
// output is the head word one edge later. A word pushed into an empty buffer
// therefore shows up one edge after the push. When the only held word is popped
// in the same edge a new word is pushed, the new word lands in the very slot
// being read, so a small bypass register supplies it without a bubble.
module instr_input_buffer
    import memboard_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int BLOCK_LEN  = BLOCK_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_write,
    input  logic [PIPE_W-1:0]     pipe_data,
    output logic                  pipe_ready,
    input  logic                  flush,
    output logic                  din_empty,
    input  logic                  din_read,
    output logic [INSTR_W-1:0]    din,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] BLOCK_C   = CW'(BLOCK_LEN);
    localparam logic          READY_RST = ((1 << DEPTH_LOG2) >= BLOCK_LEN);

    // Packing state.
    logic          half_pending_q;
    half_t         low_half_q;

    // FIFO bookkeeping.
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Output stage.
    logic          din_valid_q;
    logic          din_valid_d;
    logic          use_byp_q;
    logic          use_byp_d;
    instr_t        byp_q;
    logic          pipe_ready_q;
    logic          pipe_ready_d;

    // Sticky flags.
    logic          overflow_q;
    logic          underflow_q;

    // Datapath.
    logic          push_req;
    instr_t        push_word;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] rd_addr;
    instr_t        ram_rd_data;

    // Decode push/pop for this edge and compute next-state bookkeeping.
    always_comb begin
        push_req  = pipe_write && half_pending_q;
        push_word = pack_halves(pipe_data, low_half_q);
        full      = (count_q == DEPTH_C);
        do_push   = push_req && !full && !flush;
        do_pop    = din_read && din_valid_q && !flush;

        count_d   = count_q + CW'(do_push) - CW'(do_pop);

        // Address the slot that will be the head after this edge.
        rd_addr   = do_pop ? (rptr_q + AW'(1)) : rptr_q;

        // The only held word leaves while a new one arrives into the read slot.
        use_byp_d   = do_push && do_pop && (count_q == CW'(1));
        // Words pushed on earlier edges are readable now; this edge's push is not.
        din_valid_d = (count_q > CW'(do_pop)) || use_byp_d;

        pipe_ready_d = ((DEPTH_C - count_d) >= BLOCK_C);
    end

    sdp_ram #(
        .ADDR_W (AW),
        .DATA_W (INSTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wptr_q),
        .wr_data (push_word),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Half-word packing: alternate low/high, pending half dropped on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_pending_q <= 1'b0;
            low_half_q     <= '0;
        end else if (flush) begin
            half_pending_q <= 1'b0;
            low_half_q     <= '0;
        end else if (pipe_write) begin
            half_pending_q <= !half_pending_q;
            if (!half_pending_q) begin
                low_half_q <= pipe_data;
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the RAM depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // FWFT presentation state, bypass capture and registered pipe_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_valid_q  <= 1'b0;
            use_byp_q    <= 1'b0;
            byp_q        <= '0;
            pipe_ready_q <= READY_RST;
        end else if (flush) begin
            din_valid_q  <= 1'b0;
            use_byp_q    <= 1'b0;
            byp_q        <= '0;
            pipe_ready_q <= READY_RST;
        end else begin
            din_valid_q  <= din_valid_d;
            use_byp_q    <= use_byp_d;
            if (use_byp_d) begin
                byp_q <= push_word;
            end
            pipe_ready_q <= pipe_ready_d;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end
            if (din_read && !din_valid_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Output drive; din reads as zero whenever nothing is presented.
    always_comb begin
        din        = '0;
        if (din_valid_q) begin
            din = use_byp_q ? byp_q : ram_rd_data;
        end
        din_empty  = !din_valid_q;
        count      = count_q;
        pipe_ready = pipe_ready_q;
        overflow   = overflow_q;
        underflow  = underflow_q;
    end

endmodule

// File: doc/instr_input_buffer.md
INSTR_INPUT_BUFFER -- requirements
Module: instr_input_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 9; FIFO depth is 2**DEPTH_LOG2 32-bit instruction words.
REQ-002 Parameter BLOCK_LEN, default 64; host block-transfer length in 32-bit words, used for pipe_ready.
REQ-003 clk  input  1  single clock; all logic in this domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pipe_write  input  1  host pipe-in strobe; pipe_data valid this cycle.
REQ-006 pipe_data  input  16  host 16-bit half-word.
REQ-007 pipe_ready  output  1  high when the host may start one BLOCK_LEN-word block.
REQ-008 flush  input  1  synchronous clear of buffer, pending half and flags.
REQ-009 din_empty  output  1  high when no instruction is presented on din.
REQ-010 din_read  input  1  consumer pop strobe from memory_control.
REQ-011 din  output  32  head instruction word, first-word-fall-through (FWFT).
REQ-012 count  output  DEPTH_LOG2+1  complete 32-bit words held, including the presented word.
REQ-013 overflow  output  1  sticky; a word was dropped because the buffer was full.
REQ-014 underflow  output  1  sticky; din_read was seen while din_empty=1.

Function
REQ-015 Packing: the first accepted pipe_write after reset or flush SHALL load the low half; the next SHALL form {pipe_data, low} and push it; halves alternate thereafter.
REQ-016 A push completed at clock edge E SHALL make the word visible (din_empty=0, din valid) after edge E+1 if the buffer was empty.
REQ-017 din SHALL hold the oldest word, stable while din_empty=0 and din_read=0.
REQ-018 din_read with din_empty=0 at edge E SHALL pop; the next word, if any, SHALL be presented after edge E, with no bubble.
REQ-019 din_read with din_empty=1 SHALL be ignored and SHALL set underflow.
REQ-020 A push while count=2**DEPTH_LOG2 SHALL drop the word, set overflow, and leave the contents and count unchanged.
REQ-021 A push and a pop at the same edge with count>=1 SHALL leave count unchanged and preserve order.
REQ-022 Read and write pointers are DEPTH_LOG2 bits and SHALL wrap naturally; full/empty are derived from count.
REQ-023 pipe_ready SHALL be registered and equal (2**DEPTH_LOG2 - count) >= BLOCK_LEN, evaluated on the post-edge count.
REQ-024 flush SHALL take priority over pipe_write and din_read at the same edge: count=0, din_empty=1, pending half discarded, overflow=underflow=0.

Reset
REQ-025 While rst=1, outputs SHALL be: din_empty=1, din=0, count=0, pipe_ready=1, overflow=0, underflow=0; pending half cleared; pointers 0.
REQ-026 Reset SHALL act immediately, without waiting for a clock edge, including mid-pair or mid-block; the first write after release is a low half.

Structure
REQ-027 Package memboard_pkg SHALL hold INSTR_W=32, PIPE_W=16, and the DEPTH_LOG2/BLOCK_LEN defaults.
REQ-028 Storage SHALL be one sub-module, sdp_ram: simple dual-port, synchronous read, no reset on the array.
REQ-029 The FWFT output register, pointers, count, packing and flags SHALL reside in instr_input_buffer.

Verification
REQ-030 Reset; write 0x0001,0x0000,0x0002,0x0000 -> din=0x00000001, din_empty low one edge after the 2nd write; pop -> din=0x00000002 next cycle; pop -> din_empty=1, count=0.
REQ-031 Defaults; push 448 words -> count=448, pipe_ready=1; push a 449th -> pipe_ready=0; pop one -> pipe_ready=1.
REQ-032 Push 512 words, then write 0xAAAA,0xBBBB -> count=512, overflow=1; pop all 512 -> original sequence intact; din_read while empty -> underflow=1.
REQ-033 count=1; push and pop at the same edge for 600 cycles across the pointer wrap -> count stays 1 and order is preserved.
REQ-034 Write 0x1234 then flush, then write 0xBEEF,0xDEAD -> din=0xDEADBEEF and flags cleared.
REQ-035 Assert rst between edges with count=5 and a half pending -> outputs at reset values immediately; after release, 0x0003,0x0000 -> din=0x00000003.
